// File: rtl/maxpool_stream_ctrl.sv
// maxpool_stream_ctrl: frame sequencer emitting stride-aligned pool windows with valid/ready backpressure
module maxpool_stream_ctrl #(
  parameter int K_S  = 2,
  parameter int W_IN = 32,
  parameter int H_IN = 32,
  parameter int CW   = $clog2(W_IN),
  parameter int RW   = $clog2(H_IN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          pool_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          busy,
  output logic          frame_done
);
  localparam int SW = K_S > 1 ? $clog2(K_S) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] col, oc;
  logic [RW-1:0] row, orow;
  logic [SW-1:0] sub_c, sub_r;
  logic          col_wrap, sc_wrap, sr_wrap, last, emit;
  assign in_ready   = state == RUN && !(out_valid && !out_ready);
  assign pool_en    = in_valid && in_ready;
  assign col_wrap   = col == CW'(W_IN - 1);
  assign sc_wrap    = sub_c == SW'(K_S - 1);
  assign sr_wrap    = sub_r == SW'(K_S - 1);
  assign last       = col_wrap && row == RW'(H_IN - 1);
  assign emit       = pool_en && sc_wrap && sr_wrap;
  assign busy       = state == RUN || state == DRAIN;
  assign frame_done = state == DONE;
  always_comb begin
    state_n = state == IDLE  ? (start ? RUN : IDLE) :
              state == RUN   ? (pool_en && last ? DRAIN : RUN) :
              state == DRAIN ? (!out_valid || out_ready ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      sub_c     <= '0;
      sub_r     <= '0;
      oc        <= '0;
      orow      <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        col   <= '0;
        row   <= '0;
        sub_c <= '0;
        sub_r <= '0;
        oc    <= '0;
        orow  <= '0;
      end else if (pool_en) begin
        col   <= col_wrap ? '0 : col + 1'b1;
        row   <= col_wrap ? row + 1'b1 : row;
        sub_c <= col_wrap || sc_wrap ? '0 : sub_c + 1'b1;
        sub_r <= !col_wrap ? sub_r : sr_wrap ? '0 : sub_r + 1'b1;
        oc    <= col_wrap ? '0 : sc_wrap ? oc + 1'b1 : oc;
        orow  <= col_wrap && sr_wrap ? orow + 1'b1 : orow;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_col   <= oc;
        out_row   <= orow;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_col   <= '0;
        out_row   <= '0;
      end
    end
  end
endmodule
